pulse_stretcher: RTL and testbench

//  Converts single-cycle event pulses into fixed-width level windows separated by a guaranteed low gap.

---
 rtl/pulse_stretcher.sv | 122 ++++++++++++
 tb/tb_pulse_stretcher.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width high windows separated by a guaranteed low gap.
// Events arriving mid-window are queued in a saturating counter and replayed in order.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_i,
  input  logic              clr_ovf_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [CW-1:0]     HIGH_LD  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     LOW_LD   = CW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, busy_q;

  logic launch_pt;
  logic do_launch;
  logic ovf_set;

  // A launch point is IDLE or the final GAP cycle; only there may a new window start.
  assign launch_pt = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == '0));
  assign do_launch = launch_pt && ((pend_q != '0) || pulse_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_set = 1'b0;

    if (launch_pt) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1) + PEND_W'(pulse_i);
      end
    end else if (pulse_i) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (do_launch) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LD;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = LOW_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (do_launch) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ovf_d = ovf_set ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher against a timeline model: windows tracked by start cycle,
// queue as an integer count, outputs derived from where the current cycle falls in the window.
module tb_pulse_stretcher;

  localparam int H        = 3;
  localparam int L        = 2;
  localparam int PW       = 2;
  localparam int PEND_MAX = (1 << PW) - 1;
  localparam int NO_WIN   = -1000;

  logic          clk;
  logic          rst_n;
  logic          pulse_i;
  logic          clr_ovf_i;
  logic          level_o;
  logic          busy_o;
  logic [PW-1:0] pend_o;
  logic          ovf_o;

  int n_checks;
  int n_pass;

  // model state
  int t;
  int win_start;
  int m_pend;
  bit m_ovf;

  pulse_stretcher #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_i  (pulse_i),
    .clr_ovf_i(clr_ovf_i),
    .level_o  (level_o),
    .busy_o   (busy_o),
    .pend_o   (pend_o),
    .ovf_o    (ovf_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, t, got, exp);
  endtask

  function automatic bit in_window(input int c);
    return (c >= win_start) && (c <= win_start + H + L - 1);
  endfunction

  task automatic check_outputs();
    bit act;
    act = in_window(t);
    check("level", int'(level_o), int'(act && (t < win_start + H)));
    check("busy",  int'(busy_o),  int'(act));
    check("pend",  int'(pend_o),  m_pend);
    check("ovf",   int'(ovf_o),   int'(m_ovf));
  endtask

  task automatic model_update(input bit p, input bit c, input bit r);
    bit act, launch_pt, set;
    if (!r) begin
      win_start = NO_WIN;
      m_pend    = 0;
      m_ovf     = 1'b0;
    end else begin
      act       = in_window(t);
      launch_pt = !act || (t == win_start + H + L - 1);
      set       = 1'b0;
      if (launch_pt) begin
        if (m_pend > 0 || p) begin
          win_start = t + 1;
          if (m_pend > 0) m_pend = m_pend - 1 + int'(p);
        end
      end else if (p) begin
        if (m_pend < PEND_MAX) m_pend++;
        else set = 1'b1;
      end
      if (set) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
    t++;
  endtask

  // driver: check this cycle's outputs, then apply inputs sampled at the next edge
  task automatic step(input bit p, input bit c, input bit r);
    @(negedge clk);
    check_outputs();
    pulse_i   = p;
    clr_ovf_i = c;
    rst_n     = r;
    model_update(p, c, r);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int thr;
    n_checks  = 0;
    n_pass    = 0;
    t         = 0;
    win_start = NO_WIN;
    m_pend    = 0;
    m_ovf     = 1'b0;
    rst_n     = 1'b0;
    pulse_i   = 1'b0;
    clr_ovf_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single pulse
    step(1'b1, 1'b0, 1'b1);
    idle_cycles(8);
    // three back-to-back pulses
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    idle_cycles(18);
    // five-cycle burst: queue saturates, last event overflows
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    idle_cycles(22);
    // pulse on last gap cycle
    step(1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    step(1'b1, 1'b0, 1'b1);
    idle_cycles(10);
    // clear colliding with overflow, then clear alone
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle_cycles(3);
    // reset mid-window with queue and ovf set, pulse held during reset
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle_cycles(5);

    // randomized phases of varying pulse density
    for (int ph = 0; ph < 15; ph++) begin
      thr = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < thr,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 299) != 0);
      end
    end
    @(negedge clk);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
